// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer core.
package reaction_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_GO,
      ST_DONE,
      ST_EARLY
   } state_t;

   localparam logic [15:0] BCD_MAX           = 16'h9999;
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;  // x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   // Right-shifting Galois step; a nonzero state never reaches zero.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// Four-digit packed BCD counter with synchronous clear and ripple-carry increment.
module bcd_counter4 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] value
);

   logic [15:0] value_inc;

   always_comb begin
      logic carry;
      value_inc = value;
      carry     = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (carry) begin
            if (value[4*i +: 4] >= 4'd9) begin
               value_inc[4*i +: 4] = 4'd0;
            end else begin
               value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= value_inc;
      end
   end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: random wait, GO stimulus, BCD reaction count with saturation.
// Optional best-time register enabled by defining BEST_TIME_EN.
module reaction_timer_core
   import reaction_timer_pkg::*;
#(
   parameter int unsigned DELAY_MIN       = 1000,
   parameter int unsigned DELAY_RAND_BITS = 12,
   parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        react,
   output logic        led_go,
   output logic [15:0] time_bcd,
   output logic        done,
   output logic        early,
   output logic        timeout
`ifdef BEST_TIME_EN
   ,
   output logic [15:0] best_bcd
`endif
);

   localparam int unsigned CNT_W = $clog2(DELAY_MIN + (1 << DELAY_RAND_BITS)) + 1;

   state_t             state, state_next;
   logic [CNT_W-1:0]   delay_cnt, delay_next;
   logic [15:0]        lfsr;
   logic               start_q, react_q, start_arm;
   logic               start_rise, react_rise;
   logic               timeout_next;
   logic               cnt_clr, cnt_inc;

   // start_arm blocks a start level held through reset until it has been seen low.
   assign start_rise = start & ~start_q & start_arm;
   assign react_rise = react & ~react_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q   <= 1'b0;
         react_q   <= 1'b0;
         start_arm <= 1'b0;
         lfsr      <= LFSR_SEED;
      end else begin
         start_q   <= start;
         react_q   <= react;
         start_arm <= start_arm | ~start;
         lfsr      <= lfsr_next(lfsr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         delay_cnt <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_next;
         delay_cnt <= delay_next;
         timeout   <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state;
      delay_next   = delay_cnt;
      timeout_next = timeout;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_EARLY: begin
            if (start_rise) begin
               state_next   = ST_WAIT;
               delay_next   = CNT_W'(DELAY_MIN) + CNT_W'(lfsr[DELAY_RAND_BITS-1:0]);
               timeout_next = 1'b0;
               cnt_clr      = 1'b1;
            end
         end
         ST_WAIT: begin
            if (react_rise) begin
               state_next = ST_EARLY;
            end else begin
               delay_next = delay_cnt - CNT_W'(1);
               if (delay_cnt == CNT_W'(1)) begin
                  state_next = ST_GO;
               end
            end
         end
         ST_GO: begin
            if (react_rise) begin
               state_next = ST_DONE;
            end else if (time_bcd == BCD_MAX) begin
               state_next   = ST_DONE;
               timeout_next = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign led_go = (state == ST_GO);
   assign done   = (state == ST_DONE);
   assign early  = (state == ST_EARLY);

   bcd_counter4 u_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .value (time_bcd)
   );

`ifdef BEST_TIME_EN
   // Only a react press ends GO without timeout, so that is the update point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_bcd <= BCD_MAX;
      end else if (state == ST_GO && react_rise && time_bcd < best_bcd) begin
         best_bcd <= time_bcd;
      end
   end
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed self-checking bench for reaction_timer_core (DELAY_MIN=3, DELAY_RAND_BITS=2).
module tb_reaction_timer_core;

   logic        clk = 1'b0;
   logic        rst, start, react;
   logic        led_go, done, early, timeout;
   logic [15:0] time_bcd;
`ifdef BEST_TIME_EN
   logic [15:0] best_bcd;
`endif

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_lfsr;

   reaction_timer_core #(
      .DELAY_MIN       (3),
      .DELAY_RAND_BITS (2),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .react    (react),
      .led_go   (led_go),
      .time_bcd (time_bcd),
      .done     (done),
      .early    (early),
      .timeout  (timeout)
`ifdef BEST_TIME_EN
      ,
      .best_bcd (best_bcd)
`endif
   );

   always #5 clk = ~clk;

   // Independent LFSR model used to predict the random wait length.
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse, check cleared outputs, then wait for GO and check the wait length.
   task automatic begin_trial(input string tag);
      int exp_len;
      int n;
      exp_len = 1 + 3 + int'(m_lfsr[1:0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      check({tag, "_clr"}, {led_go, done, early, timeout, time_bcd}, 32'h0);
      while (!led_go && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_wait"}, n, exp_len);
   endtask

   task automatic press_after(input int n);
      repeat (n) tick();
      react = 1'b1;
      tick();
      react = 1'b0;
   endtask

   initial begin
      int k;
      logic bad_digit;
      rst = 1'b1; start = 1'b1; react = 1'b0;
      tick(); tick();
      check("rst_outs", {led_go, done, early, timeout, time_bcd}, 32'h0);
      check("rst_lfsr", dut.lfsr, 32'hACE1);
`ifdef BEST_TIME_EN
      check("rst_best", best_bcd, 32'h9999);
`endif
      rst = 1'b0;
      // start held high across reset must not launch a trial
      repeat (10) tick();
      check("held_start", {led_go, done, early, timeout, time_bcd}, 32'h0);
      start = 1'b0;
      tick(); tick();

      // react on GO cycle 11 -> 10 increments recorded
      begin_trial("t10");
      press_after(10);
      check("t10_res", {led_go, done, early, timeout, time_bcd}, {16'h0, 4'b0100, 16'h0010});
      press_after(2);
      tick();
      check("t10_hold", {done, time_bcd}, {15'h0, 1'b1, 16'h0010});

      // react on the first GO cycle reports zero
      begin_trial("t0");
      press_after(0);
      check("t0_res", {led_go, done, timeout, time_bcd}, {16'h0, 3'b010, 16'h0000});

      // false start on the second WAIT cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      react = 1'b1;
      tick();
      react = 1'b0;
      check("early_res", {led_go, done, early, time_bcd}, {16'h0, 3'b001, 16'h0000});
      repeat (8) tick();
      check("early_hold", {led_go, early, time_bcd}, {16'h0, 2'b01, 16'h0000});

      // restart from EARLY, then start in GO is ignored, then reset at 0042
      begin_trial("re");
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("go_ign_start", {led_go, time_bcd}, {15'h0, 1'b1, 16'h0002});
      repeat (40) tick();
      check("go_42", time_bcd, 32'h0042);
      #2 rst = 1'b1;
      #1;
      check("midgo_rst", {led_go, done, early, timeout, time_bcd}, 32'h0);
      check("midgo_lfsr", dut.lfsr, 32'hACE1);
      tick();
      rst = 1'b0;
      tick(); tick();

`ifdef BEST_TIME_EN
      begin_trial("b50");
      press_after(50);
      check("b50_best", best_bcd, 32'h0050);
      begin_trial("b30");
      press_after(30);
      begin_trial("b70");
      press_after(70);
      check("b70_time", time_bcd, 32'h0070);
      check("best_final", best_bcd, 32'h0030);
`endif

      // full saturation run with carry boundaries and digit legality
      begin_trial("sat");
      bad_digit = 1'b0;
      k = 0;
      for (int i = 1; i <= 10010; i++) begin
         tick();
         k = i;
         for (int d = 0; d < 4; d++) begin
            if (time_bcd[4*d +: 4] > 4'd9) bad_digit = 1'b1;
         end
         if (i == 99)   check("c0099", time_bcd, 32'h0099);
         if (i == 100)  check("c0100", time_bcd, 32'h0100);
         if (i == 999)  check("c0999", time_bcd, 32'h0999);
         if (i == 1000) check("c1000", time_bcd, 32'h1000);
         if (done) break;
      end
      check("sat_cycles", k, 10000);
      check("sat_res", {led_go, done, early, timeout, time_bcd}, {16'h0, 4'b0101, 16'h9999});
      check("digits_ok", bad_digit, 1'b0);
      repeat (5) tick();
      check("sat_hold", {done, timeout, time_bcd}, {14'h0, 2'b11, 16'h9999});
`ifdef BEST_TIME_EN
      check("sat_best", best_bcd, 32'h0030);
`endif
      begin_trial("after_sat");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reaction_timer_core.md
REACTION_TIMER_CORE -- requirements
Module: reaction_timer_core

Interface
REQ-001 Parameter DELAY_MIN, default 1000, minimum random wait in clk cycles (ms at 1 kHz), legal range >= 1.
REQ-002 Parameter DELAY_RAND_BITS, default 12, number of LFSR bits added to DELAY_MIN, giving 0..4095 extra cycles.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value, nonzero.
REQ-004 clk  in  1  divided timer clock from the upstream clock divider; one cycle = 1 ms nominal.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  start button level, clk-synchronous and debounced upstream.
REQ-007 react  in  1  reaction button level, clk-synchronous and debounced upstream.
REQ-008 led_go  out  1  stimulus LED, high only in GO.
REQ-009 time_bcd  out  16  reaction time as 4 packed BCD digits, [15:12] thousands.
REQ-010 done  out  1  high in DONE (valid result held).
REQ-011 early  out  1  high in EARLY (false start).
REQ-012 timeout  out  1  high in DONE when the count saturated at 9999.
REQ-013 best_bcd  out  16  best valid time so far, present only under BEST_TIME_EN.

Function
REQ-014 The core SHALL rising-edge detect start and react with one register each: rise = level & ~level_q.
REQ-015 A 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL advance every cycle in all states and never hold zero.
REQ-016 States SHALL be IDLE, WAIT, GO, DONE and EARLY.
REQ-017 In IDLE, DONE or EARLY, start_rise SHALL move to WAIT and load delay_cnt = DELAY_MIN + lfsr[DELAY_RAND_BITS-1:0].
- The same edge SHALL clear time_bcd, done, early and timeout.
REQ-018 WAIT SHALL decrement delay_cnt each cycle.
- When delay_cnt==1, the next state is GO, so WAIT lasts exactly the loaded number of cycles.
REQ-019 react_rise in WAIT SHALL move to EARLY, with priority over the delay expiring in the same cycle; time_bcd stays 0.
REQ-020 In GO, led_go SHALL be 1 (registered; it rises on the first GO cycle).
- time_bcd SHALL increment by 1 in BCD on every GO cycle without react_rise.
REQ-021 react_rise in GO SHALL move to DONE with no increment in that cycle.
- A press in the first GO cycle therefore reports 0000.
REQ-022 If time_bcd==16'h9999 in GO without react_rise, the core SHALL move to DONE with timeout=1 and time_bcd held at 9999.
REQ-023 The BCD increment SHALL ripple carries digit by digit (9 -> 0 with carry); no digit may exceed 9.
REQ-024 start_rise in WAIT or GO SHALL be ignored; react_rise in IDLE, DONE or EARLY SHALL be ignored.
REQ-025 DONE and EARLY SHALL hold all outputs stable until start_rise.

Reset
REQ-026 Asserting rst at any time, including mid-WAIT or mid-GO, SHALL force the following immediately:
- state IDLE, delay_cnt 0, edge registers 0
- led_go, done, early, timeout all 0; time_bcd 0
- lfsr = LFSR_SEED; best_bcd 16'h9999.
REQ-027 After rst deasserts, a start held high SHALL NOT register as an edge until it has been seen low.

Configuration
REQ-028 With BEST_TIME_EN defined, best_bcd SHALL load time_bcd on every GO->DONE transition with timeout=0 and time_bcd < best_bcd.
- The comparison is an unsigned compare of the packed BCD value.
REQ-029 Without BEST_TIME_EN, the best_bcd port and its register SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 A package reaction_timer_pkg SHALL hold the state enum, BCD_MAX (16'h9999), the LFSR tap mask and the default seed.
REQ-031 The BCD increment SHALL be a sub-module bcd_counter4 with inputs clr, inc and output value; the saturate/timeout decision stays in the core.

Verification (DELAY_MIN=3, DELAY_RAND_BITS=2, seed 16'hACE1)
REQ-032 Reset, start pulse, react held low:
- WAIT lasts 3 + (lfsr[1:0] at the start edge) cycles, then led_go=1.
- After 9999 GO cycles: done=1, timeout=1, time_bcd=16'h9999.
REQ-033 start, then react_rise on GO cycle 11 (10 increments done) -> done=1, time_bcd=16'h0010, led_go=0, timeout=0.
REQ-034 start, then react_rise on the second WAIT cycle -> early=1, led_go never 1, time_bcd=0.
- A following start -> WAIT with early cleared.
REQ-035 Force time_bcd through 0099 and 0999 -> next values 0100 and 1000, all digits <= 9.
REQ-036 rst pulsed mid-GO at count 0042 -> IDLE, all outputs 0, lfsr=ACE1.
- BEST_TIME_EN trials of 0050 then 0030 then 0070 -> best_bcd=0030.
